// File: rtl/mem_pkg.sv
// Shared MEM-stage definitions: load/store size encodings, access FSM states, fault causes
// and the store lane builder used when a store is latched.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_DONE
  } state_e;

  typedef struct packed {
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } lanes_t;

  // Unsigned sizes have no store form, so BU/HU are only legal on loads.
  function automatic logic f3_illegal(input logic [2:0] f3, input logic we);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b0;
      F3_BU, F3_HU:     return we;
      default:          return 1'b1;
    endcase
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_H, F3_HU: return off[0];
      F3_W:        return off != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  function automatic lanes_t store_lanes(input logic [2:0] f3, input logic [1:0] off,
                                         input logic [31:0] d);
    lanes_t l;
    case (f3[1:0])
      2'b00: begin
        l.wdata = {4{d[7:0]}};
        l.wstrb = 4'b0001 << off;
      end
      2'b01: begin
        l.wdata = {2{d[15:0]}};
        l.wstrb = 4'b0011 << off;
      end
      default: begin
        l.wdata = d;
        l.wstrb = 4'b1111;
      end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load alignment: picks the byte/half at the address offset and sign- or
// zero-extends it according to funct3; words pass through untouched.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (off)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data = {24'b0, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data = {16'b0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer: one valid/ready request per access, store done 2 cycles after
// accept, load 3+; holds the pipeline via out_stall until done, times out a silent bus.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic [2:0]        in_funct3,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_wdata,
  output logic              out_req_valid,
  input  logic              in_req_ready,
  output logic [ADDR_W-1:0] out_req_addr,
  output logic              out_req_we,
  output logic [3:0]        out_req_wstrb,
  output logic [31:0]       out_req_wdata,
  input  logic              in_resp_valid,
  input  logic [31:0]       in_resp_rdata,
  output logic              out_stall,
  output logic              out_done,
  output logic [31:0]       out_load_data,
  output logic              out_fault,
  output logic [1:0]        out_fault_cause
);

  // Counter is wide enough to step one past the limit when a late handshake lands on it.
  localparam int CW     = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 2);
  localparam int TLIM_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CW-1:0] TLIM = TLIM_I[CW-1:0];

  state_e            state;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        f3_q;
  logic              we_q;
  logic [3:0]        wstrb_q;
  logic [31:0]       wdata_q;
  logic [31:0]       load_q;
  logic              tmo_q;
  logic [CW-1:0]     cnt;

  logic        op;
  logic        in_we;
  logic        in_illegal;
  logic        in_misal;
  logic        accept;
  logic        idle_fault;
  logic        tmo_hit;
  logic        tmo_done;
  lanes_t      lanes;
  logic [31:0] aligned;

  // A read+write collision resolves to a load.
  assign op         = in_valid & (in_mem_read | in_mem_write);
  assign in_we      = in_mem_write & ~in_mem_read;
  assign in_illegal = f3_illegal(in_funct3, in_we);
  assign in_misal   = f3_misaligned(in_funct3, in_addr[1:0]);
  assign accept     = (state == S_IDLE) & op & ~in_illegal & ~in_misal;
  assign idle_fault = (state == S_IDLE) & op & (in_illegal | in_misal);
  assign lanes      = store_lanes(in_funct3, in_addr[1:0], in_wdata);
  assign tmo_hit    = (TIMEOUT_CYCLES != 0) && (cnt >= TLIM);
  assign tmo_done   = (state == S_DONE) & tmo_q;

  load_align u_load_align (
    .rdata  (in_resp_rdata),
    .off    (addr_q[1:0]),
    .funct3 (f3_q),
    .data   (aligned)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      wstrb_q <= '0;
      wdata_q <= '0;
      load_q  <= '0;
      tmo_q   <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            addr_q  <= in_addr;
            f3_q    <= in_funct3;
            we_q    <= in_we;
            wstrb_q <= in_we ? lanes.wstrb : 4'b0000;
            wdata_q <= in_we ? lanes.wdata : 32'b0;
            load_q  <= '0;
            tmo_q   <= 1'b0;
            cnt     <= '0;
            state   <= S_REQ;
          end
        end
        S_REQ: begin
          cnt <= cnt + CW'(1);
          if (in_req_ready) begin
            state <= we_q ? S_DONE : S_RESP;
          end else if (tmo_hit) begin
            tmo_q <= 1'b1;
            state <= S_DONE;
          end
        end
        S_RESP: begin
          cnt <= cnt + CW'(1);
          if (in_resp_valid) begin
            load_q <= aligned;
            state  <= S_DONE;
          end else if (tmo_hit) begin
            tmo_q <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign out_req_valid = (state == S_REQ);
  assign out_req_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign out_req_we    = we_q;
  assign out_req_wstrb = wstrb_q;
  assign out_req_wdata = wdata_q;

  // The accept-cycle stall is combinational, so it is masked while reset is held.
  assign out_stall     = reset_n & (accept | (state == S_REQ) | (state == S_RESP));
  assign out_done      = (state == S_DONE);
  assign out_load_data = (state == S_DONE) ? load_q : 32'b0;

  always_comb begin
    out_fault       = 1'b0;
    out_fault_cause = CAUSE_NONE;
    if (tmo_done) begin
      out_fault       = 1'b1;
      out_fault_cause = CAUSE_TIMEOUT;
    end else if (idle_fault & reset_n) begin
      out_fault       = 1'b1;
      out_fault_cause = in_illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGN;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed cases plus randomized load/store traffic
// against an arithmetic reference model and a behavioural memory responder.
module tb_mem_access_unit;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0, in_mem_read = 1'b0, in_mem_write = 1'b0;
  logic [2:0]  in_funct3 = '0;
  logic [31:0] in_addr = '0, in_wdata = '0;
  logic        out_req_valid, in_req_ready = 1'b0;
  logic [31:0] out_req_addr;
  logic        out_req_we;
  logic [3:0]  out_req_wstrb;
  logic [31:0] out_req_wdata;
  logic        in_resp_valid = 1'b0;
  logic [31:0] in_resp_rdata = '0;
  logic        out_stall, out_done, out_fault;
  logic [31:0] out_load_data;
  logic [1:0]  out_fault_cause;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(TMO), .ADDR_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write), .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
    .out_req_valid(out_req_valid), .in_req_ready(in_req_ready), .out_req_addr(out_req_addr),
    .out_req_we(out_req_we), .out_req_wstrb(out_req_wstrb), .out_req_wdata(out_req_wdata),
    .in_resp_valid(in_resp_valid), .in_resp_rdata(in_resp_rdata), .out_stall(out_stall),
    .out_done(out_done), .out_load_data(out_load_data), .out_fault(out_fault),
    .out_fault_cause(out_fault_cause)
  );

  typedef struct {
    logic [31:0] addr;
    bit          we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    bit          fault_only;
    bit          tmo;
    bit          drop_req;
    logic [1:0]  cause;
    logic [31:0] ld;
    int          t_issue;
    int          lat;
  } exp_t;

  req_t        rq[$];
  exp_t        sb[$];
  logic [31:0] rdq[$];

  int n_chk = 0, n_fail = 0, cyc = 0;
  int ready_mode = 1, resp_mode = 1, hold = 0;
  bit quiet = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference model: sizes in bytes, lanes by index arithmetic, extension by integer range.
  function automatic void model(input bit v, input bit r, input bit w, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                                output bit op, output bit flt, output logic [1:0] cause,
                                output req_t q, output logic [31:0] ld);
    int off, sz, val;
    bit we;
    logic [31:0] word;
    op = v && (r || w);
    we = w && !r;
    off = int'(a[1:0]);
    case (f3)
      3'd0, 3'd4: sz = 1;
      3'd1, 3'd5: sz = 2;
      3'd2:       sz = 4;
      default:    sz = 0;
    endcase
    flt = 1'b0;
    cause = 2'b00;
    ld = '0;
    q.addr = a & ~32'h3;
    q.we = we;
    q.wstrb = '0;
    q.wdata = '0;
    if (sz == 0 || (we && f3[2])) begin
      flt = 1'b1;
      cause = 2'b10;
    end else if (off % sz != 0) begin
      flt = 1'b1;
      cause = 2'b01;
    end
    if (!flt) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          q.wdata[8*i +: 8] = wd[8*(i % sz) +: 8];
          if (i >= off && i < off + sz) q.wstrb[i] = 1'b1;
        end
      end else begin
        word = rd >> (8 * off);
        if (sz == 4) ld = rd;
        else begin
          val = (sz == 1) ? int'(word & 32'hFF) : int'(word & 32'hFFFF);
          if (!f3[2] && val >= (1 << (8 * sz - 1))) val -= (1 << (8 * sz));
          ld = 32'(val);
        end
      end
    end
  endfunction

  task automatic issue(input bit v, input bit r, input bit w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                       input int lat, input bit tmo, input bit drop);
    bit op, flt, ok;
    logic [1:0] cause;
    req_t q;
    logic [31:0] ld;
    exp_t e;
    model(v, r, w, f3, a, wd, rd, op, flt, cause, q, ld);
    @(posedge clk);
    #1;
    in_valid = v; in_mem_read = r; in_mem_write = w;
    in_funct3 = f3; in_addr = a; in_wdata = wd;
    if (op) begin
      e.fault_only = flt;
      e.tmo = tmo && !flt;
      e.drop_req = drop && !flt;
      e.cause = flt ? cause : (tmo ? 2'b11 : 2'b00);
      e.ld = (flt || tmo) ? 32'b0 : ld;
      e.t_issue = cyc;
      e.lat = flt ? 0 : lat;
      sb.push_back(e);
      if (!flt) begin
        rq.push_back(q);
        if (!q.we && !tmo) rdq.push_back(rd);
      end
    end
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!out_stall) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("stall_release_timeout");
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0;
  endtask

  // Monitor: request fields checked every valid cycle, completions popped from the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && !quiet) begin
      if (out_req_valid) begin
        check("req_stall", 32'(out_stall), 32'd1);
        if (rq.size() == 0) fail_now("req_unexpected");
        else begin
          check("req_addr", out_req_addr, rq[0].addr);
          check("req_we", 32'(out_req_we), 32'(rq[0].we));
          check("req_wstrb", 32'(out_req_wstrb), 32'(rq[0].wstrb));
          if (rq[0].we) check("req_wdata", out_req_wdata, rq[0].wdata);
          if (in_req_ready) void'(rq.pop_front());
        end
      end
      if (out_done || out_fault) begin
        if (sb.size() == 0) fail_now("completion_unexpected");
        else begin
          e = sb.pop_front();
          check("done", 32'(out_done), 32'(!e.fault_only));
          check("fault", 32'(out_fault), 32'(e.fault_only || e.tmo));
          check("cause", 32'(out_fault_cause), 32'(e.cause));
          if (!e.fault_only) check("load_data", out_load_data, e.ld);
          else begin
            check("fault_stall", 32'(out_stall), 32'd0);
            check("fault_req_valid", 32'(out_req_valid), 32'd0);
          end
          if (e.lat >= 0) check("latency", 32'(cyc - e.t_issue), 32'(e.lat));
          if (e.drop_req && rq.size() > 0) void'(rq.pop_front());
        end
      end
    end
  end

  // Memory responder: ready per mode, load data returned 1..3 cycles after the handshake.
  initial begin
    bit hs_ld, pend;
    int dcnt, lowrun;
    pend = 1'b0; dcnt = 0; lowrun = 0;
    forever begin
      @(negedge clk);
      hs_ld = reset_n && out_req_valid && in_req_ready && !out_req_we;
      @(posedge clk);
      #1;
      if (!reset_n) begin
        pend = 1'b0;
        in_resp_valid = 1'b0;
        in_req_ready = 1'b0;
        continue;
      end
      if (hs_ld) begin
        pend = 1'b1;
        dcnt = (resp_mode == 0) ? int'($urandom_range(1, 3)) : ((resp_mode == 1) ? 1 : -1);
      end
      in_resp_valid = 1'b0;
      in_resp_rdata = $urandom;
      if (pend && dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) begin
          pend = 1'b0;
          in_resp_valid = 1'b1;
          if (rdq.size() > 0) in_resp_rdata = rdq.pop_front();
        end
      end
      if (hold > 0) begin
        in_req_ready = 1'b0;
        hold--;
      end else begin
        case (ready_mode)
          1: in_req_ready = 1'b1;
          2: in_req_ready = 1'b0;
          default: in_req_ready = (lowrun >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
        endcase
      end
      lowrun = in_req_ready ? 0 : lowrun + 1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_watchdog (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit v, r, w;
    logic [2:0] f3;
    logic [2:0] legal [5];
    legal[0] = 3'b000; legal[1] = 3'b001; legal[2] = 3'b010; legal[3] = 3'b100; legal[4] = 3'b101;

    #1;
    check("rst_req_valid", 32'(out_req_valid), 32'd0);
    check("rst_stall", 32'(out_stall), 32'd0);
    check("rst_done", 32'(out_done), 32'd0);
    check("rst_fault", 32'(out_fault), 32'd0);
    check("rst_cause", 32'(out_fault_cause), 32'd0);
    check("rst_load_data", out_load_data, 32'd0);
    check("rst_req_addr", out_req_addr, 32'd0);
    check("rst_req_wstrb", 32'(out_req_wstrb), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    ready_mode = 1; resp_mode = 1;
    issue(1, 1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 3, 0, 0);
    issue(1, 1, 0, 3'b000, 32'h103, 32'h0, 32'h80000000, 3, 0, 0);
    issue(1, 1, 0, 3'b100, 32'h103, 32'h0, 32'h80000000, 3, 0, 0);
    issue(1, 1, 0, 3'b101, 32'h102, 32'h0, 32'h80000000, 3, 0, 0);
    issue(1, 1, 0, 3'b001, 32'h102, 32'h0, 32'h8001_7FFF, 3, 0, 0);
    hold = 4;
    issue(1, 0, 1, 3'b000, 32'h101, 32'h000000AB, 32'h0, 5, 0, 0);
    issue(1, 0, 1, 3'b001, 32'h102, 32'h1234CDEF, 32'h0, 2, 0, 0);
    issue(1, 0, 1, 3'b010, 32'h104, 32'hCAFEF00D, 32'h0, 2, 0, 0);
    issue(1, 1, 1, 3'b010, 32'h108, 32'h11111111, 32'h55AA55AA, 3, 0, 0);
    issue(1, 1, 0, 3'b001, 32'h101, 32'h0, 32'h0, 0, 0, 0);
    issue(1, 1, 0, 3'b010, 32'h102, 32'h0, 32'h0, 0, 0, 0);
    issue(1, 1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0, 0);
    issue(1, 0, 1, 3'b100, 32'h100, 32'h0, 32'h0, 0, 0, 0);
    issue(1, 0, 1, 3'b111, 32'h101, 32'h0, 32'h0, 0, 0, 0);
    issue(0, 1, 0, 3'b010, 32'h100, 32'h0, 32'h0, 0, 0, 0);
    issue(1, 0, 0, 3'b010, 32'h100, 32'h0, 32'h0, 0, 0, 0);

    ready_mode = 2;
    issue(1, 1, 0, 3'b010, 32'h300, 32'h0, 32'h0, TMO + 1, 1, 1);
    issue(1, 0, 1, 3'b000, 32'h305, 32'h77, 32'h0, TMO + 1, 1, 1);
    ready_mode = 1; resp_mode = 2;
    issue(1, 1, 0, 3'b101, 32'h306, 32'h0, 32'h0, TMO + 1, 1, 0);
    resp_mode = 1;
    issue(1, 1, 0, 3'b010, 32'h30C, 32'h0, 32'h0BADF00D, 3, 0, 0);
    idle_cycle();

    quiet = 1'b1;
    resp_mode = 2;
    @(posedge clk);
    #1;
    in_valid = 1'b1; in_mem_read = 1'b1; in_mem_write = 1'b0;
    in_funct3 = 3'b010; in_addr = 32'h200;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    check("pre_reset_stall", 32'(out_stall), 32'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_stall", 32'(out_stall), 32'd0);
    check("midrst_req_valid", 32'(out_req_valid), 32'd0);
    check("midrst_done", 32'(out_done), 32'd0);
    check("midrst_fault", 32'(out_fault), 32'd0);
    check("midrst_load_data", out_load_data, 32'd0);
    check("midrst_req_addr", out_req_addr, 32'd0);
    @(negedge clk);
    in_valid = 1'b0; in_mem_read = 1'b0;
    sb.delete(); rq.delete(); rdq.delete();
    @(posedge clk);
    #1 reset_n = 1'b1;
    quiet = 1'b0;
    resp_mode = 1;
    issue(1, 1, 0, 3'b010, 32'h400, 32'h0, 32'h13572468, 3, 0, 0);
    issue(1, 0, 1, 3'b010, 32'h404, 32'h89ABCDEF, 32'h0, 2, 0, 0);
    issue(1, 1, 0, 3'b000, 32'h406, 32'h0, 32'h007F0000, 3, 0, 0);

    ready_mode = 0; resp_mode = 0;
    for (int i = 0; i < 300; i++) begin
      v = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 7))
        0:          begin r = 1'b0; w = 1'b0; end
        1:          begin r = 1'b1; w = 1'b1; end
        2, 3, 4:    begin r = 1'b1; w = 1'b0; end
        default:    begin r = 1'b0; w = 1'b1; end
      endcase
      if ($urandom_range(0, 5) != 0) f3 = legal[$urandom_range(0, 4)];
      else f3 = 3'($urandom_range(0, 7));
      issue(v, r, w, f3, $urandom, $urandom, $urandom, -1, 0, 0);
    end
    idle_cycle();
    repeat (4) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    check("rq_empty", 32'(rq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
